// File: rtl/wb_uart_master_if.sv
// Wishbone master-side bundle for the UART debug/boot bridge.
//   wb_adr_o  32  byte address
//   wb_dat_o  32  write data
//   wb_dat_i  32  read data
//   wb_sel_o   4  byte selects
//   wb_we_o    1  write enable
//   wb_cyc_o   1  bus cycle
//   wb_stb_o   1  strobe
//   wb_ack_i   1  slave acknowledge
//   wb_err_i   1  slave error
interface wb_uart_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_uart_master.sv
// Serial debug/boot bridge: 8N1 command frames on uart_rxd become single
// 32-bit Wishbone read/write cycles; the result is replied on uart_txd.
//   'W' 0x57 + ADR[4] + DAT[4] -> write, reply 0x06 (ack) / 0x15 (err, timeout)
//   'R' 0x52 + ADR[4]          -> read,  reply DAT[4] (ack) / 0x15 (err, timeout)
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   uart_rxd  in   serial input, asynchronous, idle high
//   uart_txd  out  serial output, idle high
//   busy      out  high whenever the command FSM is not idle
//   bus       wb_uart_master_if.master  Wishbone master port
//
// state    | meaning
// ---------+--------------------------------------------------------
// s_idle   | waiting for a 'W' or 'R' command byte
// s_addr   | collecting 4 address bytes, MSB first
// s_data   | collecting 4 write-data bytes, MSB first (writes only)
// s_bus    | cyc/stb asserted, waiting for ack/err or bus timeout
// s_reply  | sending reply bytes back-to-back
module wb_uart_master #(
  parameter int unsigned clk_freq     = 50000000,
  parameter int unsigned baud         = 115200,
  parameter int unsigned bus_timeout  = 1024,
  parameter int unsigned idle_timeout = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rxd,
  output logic              uart_txd,
  output logic              busy,
  wb_uart_master_if.master  bus
);

  localparam int unsigned div      = clk_freq / baud;
  localparam int unsigned idle_cyc = idle_timeout * div;
  localparam int          bw       = $clog2(div + 1);
  localparam int          iw       = $clog2(idle_cyc + 1);
  localparam int          tw       = $clog2(bus_timeout + 1);

  localparam logic [bw-1:0] div_last     = bw'(div - 1);
  localparam logic [bw-1:0] half_last    = bw'(div / 2 - 1);
  localparam logic [iw-1:0] idle_last    = iw'(idle_cyc - 1);
  localparam logic [tw-1:0] timeout_last = tw'(bus_timeout - 1);

  localparam logic [7:0] cmd_write = 8'h57;
  localparam logic [7:0] cmd_read  = 8'h52;
  localparam logic [7:0] rep_ack   = 8'h06;
  localparam logic [7:0] rep_nak   = 8'h15;

  // ---------------- receiver ----------------
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          rx_active;
  logic [3:0]    rx_bit;
  logic [bw-1:0] rx_cnt;
  logic [7:0]    rx_shift;
  logic          rx_valid, rx_ferr;

  // rx_bit: 0 = start re-check, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      rx_active <= 1'b0;
      rx_bit    <= '0;
      rx_cnt    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rxd_prev && !rxd_sync) begin
          rx_active <= 1'b1;
          rx_bit    <= '0;
          rx_cnt    <= half_last;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= div_last;
        if (rx_bit == 4'd0) begin
          // line back high at mid start bit: a glitch, not a frame
          if (rxd_sync) rx_active <= 1'b0;
          else          rx_bit    <= 4'd1;
        end else if (rx_bit <= 4'd8) begin
          rx_shift <= {rxd_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end else begin
          rx_active <= 1'b0;
          if (rxd_sync) rx_valid <= 1'b1;
          else          rx_ferr  <= 1'b1;
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_active;
  logic [3:0]    tx_left;
  logic [bw-1:0] tx_cnt;
  logic [7:0]    tx_shift;
  logic          tx_load;
  logic [7:0]    tx_data;

  // Ones are shifted in behind the data so the stop bit falls out naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_txd  <= 1'b1;
      tx_active <= 1'b0;
      tx_left   <= '0;
      tx_cnt    <= '0;
      tx_shift  <= '0;
    end else if (tx_load && !tx_active) begin
      uart_txd  <= 1'b0;
      tx_active <= 1'b1;
      tx_left   <= 4'd9;
      tx_cnt    <= div_last;
      tx_shift  <= tx_data;
    end else if (tx_active) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else begin
        tx_cnt <= div_last;
        if (tx_left == 4'd0) begin
          tx_active <= 1'b0;
          uart_txd  <= 1'b1;
        end else begin
          uart_txd <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[7:1]};
          tx_left  <= tx_left - 4'd1;
        end
      end
    end
  end

  // ---------------- command FSM ----------------
  typedef enum logic [2:0] {s_idle, s_addr, s_data, s_bus, s_reply} state_t;

  state_t        state, state_next;
  logic [1:0]    byte_cnt;
  logic          is_write;
  logic [31:0]   adr_sh, dat_sh;
  logic [iw-1:0] idle_cnt;
  logic [tw-1:0] bus_cnt;
  logic [31:0]   reply_sh;
  logic [2:0]    reply_left;
  logic [31:0]   adr_q, dat_q;
  logic          we_q;
  logic          take_byte, to_bus, bus_end;

  always_ff @(posedge clk) begin
    if (reset) state <= s_idle;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_byte  = 1'b0;
    to_bus     = 1'b0;
    bus_end    = 1'b0;
    tx_load    = 1'b0;
    tx_data    = reply_sh[31:24];
    case (state)
      s_idle: begin
        if (rx_valid && (rx_shift == cmd_write || rx_shift == cmd_read))
          state_next = s_addr;
      end
      s_addr, s_data: begin
        if (rx_ferr) begin
          state_next = s_idle;
        end else if (rx_valid) begin
          take_byte = 1'b1;
          if (byte_cnt == 2'd3) begin
            if (state == s_addr && is_write) begin
              state_next = s_data;
            end else begin
              state_next = s_bus;
              to_bus     = 1'b1;
            end
          end
        end else if (idle_cnt == '0) begin
          state_next = s_idle;
        end
      end
      s_bus: begin
        if (bus.wb_ack_i || bus.wb_err_i || bus_cnt == '0) begin
          bus_end    = 1'b1;
          state_next = s_reply;
        end
      end
      s_reply: begin
        if (!tx_active) begin
          if (reply_left != 3'd0) tx_load    = 1'b1;
          else                    state_next = s_idle;
        end
      end
      default: state_next = s_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      is_write   <= 1'b0;
      adr_sh     <= '0;
      dat_sh     <= '0;
      idle_cnt   <= '0;
      bus_cnt    <= '0;
      reply_sh   <= '0;
      reply_left <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      if (state == s_idle && state_next == s_addr) begin
        is_write <= (rx_shift == cmd_write);
        byte_cnt <= '0;
      end
      if (take_byte) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == s_addr) adr_sh <= {adr_sh[23:0], rx_shift};
        else                 dat_sh <= {dat_sh[23:0], rx_shift};
      end
      // silence timer restarts on every received byte
      if (rx_valid)             idle_cnt <= idle_last;
      else if (idle_cnt != '0)  idle_cnt <= idle_cnt - 1'b1;
      // bus outputs change only when a cycle starts, so they hold afterwards
      if (to_bus) begin
        bus_cnt <= timeout_last;
        we_q    <= is_write;
        if (is_write) begin
          adr_q <= adr_sh;
          dat_q <= {dat_sh[23:0], rx_shift};
        end else begin
          adr_q <= {adr_sh[23:0], rx_shift};
        end
      end else if (state == s_bus && bus_cnt != '0) begin
        bus_cnt <= bus_cnt - 1'b1;
      end
      // err wins over ack; neither means timeout
      if (bus_end) begin
        if (bus.wb_err_i || !bus.wb_ack_i) begin
          reply_sh   <= {rep_nak, 24'h0};
          reply_left <= 3'd1;
        end else if (we_q) begin
          reply_sh   <= {rep_ack, 24'h0};
          reply_left <= 3'd1;
        end else begin
          reply_sh   <= bus.wb_dat_i;
          reply_left <= 3'd4;
        end
      end else if (tx_load) begin
        reply_sh   <= {reply_sh[23:0], 8'h00};
        reply_left <= reply_left - 3'd1;
      end
    end
  end

  assign bus.wb_cyc_o = (state == s_bus);
  assign bus.wb_stb_o = (state == s_bus);
  assign bus.wb_sel_o = (state == s_bus) ? 4'hF : 4'h0;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign busy         = (state != s_idle);

endmodule
